// File: rtl/ssd_capture_pkg.sv
// Shared 7-segment definitions: segment bit positions and the canonical hex glyphs
// used by the display encoder, the driver and this capture block.
package ssd_capture_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_HEX0  = 7'h3F;
    localparam logic [6:0] SEG_HEX1  = 7'h06;
    localparam logic [6:0] SEG_HEX2  = 7'h5B;
    localparam logic [6:0] SEG_HEX3  = 7'h4F;
    localparam logic [6:0] SEG_HEX4  = 7'h66;
    localparam logic [6:0] SEG_HEX5  = 7'h6D;
    localparam logic [6:0] SEG_HEX6  = 7'h7D;
    localparam logic [6:0] SEG_HEX7  = 7'h07;
    localparam logic [6:0] SEG_HEX8  = 7'h7F;
    localparam logic [6:0] SEG_HEX9  = 7'h67;
    localparam logic [6:0] SEG_HEXA  = 7'h77;
    localparam logic [6:0] SEG_HEXB  = 7'h7C;
    localparam logic [6:0] SEG_HEXC  = 7'h39;
    localparam logic [6:0] SEG_HEXD  = 7'h5E;
    localparam logic [6:0] SEG_HEXE  = 7'h79;
    localparam logic [6:0] SEG_HEXF  = 7'h71;

endpackage

// File: rtl/ssd_pattern_decode.sv
// Combinational inverse of the hex-to-segment encoder: glyph -> {value, legal, blank}.
module ssd_pattern_decode
    import ssd_capture_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] value,
    output logic       legal,
    output logic       blank
);

    always_comb begin
        value = 4'h0;
        legal = 1'b1;
        blank = 1'b0;
        case (pat)
            SEG_HEX0: value = 4'h0;
            SEG_HEX1: value = 4'h1;
            SEG_HEX2: value = 4'h2;
            SEG_HEX3: value = 4'h3;
            SEG_HEX4: value = 4'h4;
            SEG_HEX5: value = 4'h5;
            SEG_HEX6: value = 4'h6;
            SEG_HEX7: value = 4'h7;
            SEG_HEX8: value = 4'h8;
            SEG_HEX9: value = 4'h9;
            SEG_HEXA: value = 4'hA;
            SEG_HEXB: value = 4'hB;
            SEG_HEXC: value = 4'hC;
            SEG_HEXD: value = 4'hD;
            SEG_HEXE: value = 4'hE;
            SEG_HEXF: value = 4'hF;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_capture.sv
// Passive reader of a multiplexed 7-segment bus: per-digit glitch filtering,
// decode back to hex, and stale/illegal/blank flagging.
module ssd_capture
    import ssd_capture_pkg::*;
#(
    parameter int NDIG           = 4,
    parameter int STABLE_CNT     = 4,
    parameter int TIMEOUT_CYC    = 1024,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg,
    input  logic [NDIG-1:0]   an_n,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   valid,
    output logic [NDIG-1:0]   blank,
    output logic [NDIG-1:0]   bad,
    output logic              sel_err,
    output logic              upd
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CNT - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_PRE = TW'(TIMEOUT_CYC - 1);

    logic [6:0]      segc;
    logic [NDIG-1:0] sel_vec;
    logic            multi;
    logic            sel_one;
    logic [3:0]      dec_val;
    logic            dec_legal;
    logic            dec_blank;
    logic [NDIG-1:0] chg;

    assign segc    = (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
    assign sel_vec = ~an_n;
    assign multi   = (sel_vec & (sel_vec - NDIG'(1))) != '0;
    assign sel_one = (sel_vec != '0) && !multi;

    // Only one digit can be captured per cycle, so a single shared decoder serves all.
    ssd_pattern_decode u_dec (
        .pat   (segc),
        .value (dec_val),
        .legal (dec_legal),
        .blank (dec_blank)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
            upd     <= 1'b0;
        end else begin
            sel_err <= multi;
            upd     <= |chg;
        end
    end

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        logic          sel_me;
        logic [6:0]    last_pat, pat_d;
        logic [CW-1:0] cnt, cnt_d;
        logic [TW-1:0] tmo, tmo_d;
        logic [3:0]    dig_q, dig_d;
        logic          vld_q, vld_d, blk_q, blk_d, bad_q, bad_d;

        assign sel_me = sel_one & sel_vec[i];

        always_comb begin
            pat_d = last_pat;
            cnt_d = cnt;
            tmo_d = tmo;
            dig_d = dig_q;
            vld_d = vld_q;
            blk_d = blk_q;
            bad_d = bad_q;
            if (sel_me) begin
                tmo_d = '0;
                if (segc == last_pat) begin
                    if (cnt != CNT_MAX) cnt_d = cnt + CW'(1);
                    // Commit exactly once, on the transition into saturation.
                    if (cnt == CNT_PRE) begin
                        vld_d = dec_legal;
                        blk_d = dec_blank;
                        bad_d = !dec_legal && !dec_blank;
                        if (dec_legal)      dig_d = dec_val;
                        else if (dec_blank) dig_d = 4'h0;
                    end
                end else begin
                    pat_d = segc;
                    cnt_d = CW'(1);
                end
            end else begin
                if (tmo != TMO_MAX) tmo_d = tmo + TW'(1);
                if (tmo == TMO_PRE) begin
                    vld_d = 1'b0;
                    cnt_d = '0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                last_pat <= '0;
                cnt      <= '0;
                tmo      <= '0;
                dig_q    <= '0;
                vld_q    <= 1'b0;
                blk_q    <= 1'b0;
                bad_q    <= 1'b0;
            end else begin
                last_pat <= pat_d;
                cnt      <= cnt_d;
                tmo      <= tmo_d;
                dig_q    <= dig_d;
                vld_q    <= vld_d;
                blk_q    <= blk_d;
                bad_q    <= bad_d;
            end
        end

        assign chg[i] = {dig_d, vld_d, blk_d, bad_d} != {dig_q, vld_q, blk_q, bad_q};
        assign digits[4*i +: 4] = dig_q;
        assign valid[i] = vld_q;
        assign blank[i] = blk_q;
        assign bad[i]   = bad_q;
    end

endmodule

// File: tb/tb_ssd_capture.sv
// Self-checking bench for ssd_capture: directed scenarios plus randomized bus traffic
// compared every cycle against a run-length / elapsed-time reference model.
module tb_ssd_capture;

    localparam int ND  = 4;
    localparam int STB = 4;
    localparam int TMO = 64;

    logic            clk;
    logic            rst_n;
    logic [6:0]      seg;
    logic [ND-1:0]   an_n;
    logic [4*ND-1:0] digits;
    logic [ND-1:0]   valid, blank, bad;
    logic            sel_err, upd;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state: run length of the current pattern on each digit's own
    // selected cycles, and cycles elapsed since each digit was last selected.
    int         run   [ND];
    logic [6:0] lastp [ND];
    int         since [ND];
    logic [3:0] mdig  [ND];
    bit         mval  [ND];
    bit         mblk  [ND];
    bit         mbad  [ND];
    bit         msel_err, mupd;

    ssd_capture #(
        .NDIG(ND), .STABLE_CNT(STB), .TIMEOUT_CYC(TMO), .SEG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an_n(an_n),
        .digits(digits), .valid(valid), .blank(blank), .bad(bad),
        .sel_err(sel_err), .upd(upd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Returns 0..15 for a legal glyph, 16 for blank, -1 for an illegal pattern.
    function automatic int dec(input logic [6:0] p);
        if (p == 7'h00) return 16;
        for (int k = 0; k < 16; k++)
            if (pat_tab[k] == p) return k;
        return -1;
    endfunction

    task automatic model_step();
        int nlow;
        bit ch;
        int v;
        logic [6:0] old;
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) begin
                run[d] = 0; lastp[d] = 7'h00; since[d] = 0;
                mdig[d] = 4'h0; mval[d] = 0; mblk[d] = 0; mbad[d] = 0;
            end
            msel_err = 0;
            mupd = 0;
        end else begin
            nlow = $countones(~an_n);
            msel_err = (nlow > 1);
            ch = 0;
            for (int d = 0; d < ND; d++) begin
                old = {mdig[d], mval[d], mblk[d], mbad[d]};
                if (nlow == 1 && an_n[d] == 1'b0) begin
                    since[d] = 0;
                    if (seg == lastp[d]) run[d]++;
                    else begin lastp[d] = seg; run[d] = 1; end
                    if (run[d] == STB) begin
                        v = dec(seg);
                        if (v == 16) begin
                            mdig[d] = 4'h0; mval[d] = 0; mblk[d] = 1; mbad[d] = 0;
                        end else if (v < 0) begin
                            mval[d] = 0; mblk[d] = 0; mbad[d] = 1;
                        end else begin
                            mdig[d] = 4'(v); mval[d] = 1; mblk[d] = 0; mbad[d] = 0;
                        end
                    end
                end else begin
                    since[d]++;
                    if (since[d] == TMO) begin
                        mval[d] = 0;
                        run[d] = 0;
                    end
                end
                if ({mdig[d], mval[d], mblk[d], mbad[d]} != old) ch = 1;
            end
            mupd = ch;
        end
    endtask

    // Drive one cycle's inputs, advance the model at the edge, return at the next negedge.
    task automatic cyc(input logic r, input logic [6:0] s, input logic [ND-1:0] a);
        rst_n = r;
        seg   = s;
        an_n  = a;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [ND-1:0] one_n(input int d);
        logic [ND-1:0] m;
        m = ND'(1) << d;
        return ~m;
    endfunction

    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            logic [4*ND-1:0] ed;
            logic [ND-1:0]   ev, eb, ex;
            for (int d = 0; d < ND; d++) begin
                ed[4*d +: 4] = mdig[d];
                ev[d] = mval[d];
                eb[d] = mblk[d];
                ex[d] = mbad[d];
            end
            chk("m_digits", 32'(digits), 32'(ed));
            chk("m_valid", 32'(valid), 32'(ev));
            chk("m_blank", 32'(blank), 32'(eb));
            chk("m_bad", 32'(bad), 32'(ex));
            chk("m_sel_err", 32'(sel_err), 32'(msel_err));
            chk("m_upd", 32'(upd), 32'(mupd));
        end
    end

    initial begin
        int r, d, len;
        logic [6:0] p;
        logic [ND-1:0] a;
        rst_n = 1'b0; seg = 7'h00; an_n = '1;
        cmp_en = 1;

        // Reset with random bus activity, then idle.
        for (int i = 0; i < 3; i++) cyc(0, 7'($urandom), ND'($urandom));
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_flags", 32'({valid, blank, bad, sel_err, upd}), 32'h0);
        for (int i = 0; i < 10; i++) cyc(1, 7'($urandom), '1);
        chk("idle_digits", 32'(digits), 32'h0);
        chk("idle_flags", 32'({valid, blank, bad, sel_err, upd}), 32'h0);

        // Steady capture of 3 on digit 0.
        for (int i = 0; i < 3; i++) cyc(1, 7'h4F, 4'b1110);
        chk("steady_pre_valid", 32'(valid[0]), 32'h0);
        cyc(1, 7'h4F, 4'b1110);
        chk("steady_digit", 32'(digits[3:0]), 32'h3);
        chk("steady_valid", 32'(valid[0]), 32'h1);
        chk("steady_upd", 32'(upd), 32'h1);
        cyc(1, 7'h4F, 4'b1110);
        chk("steady_no_reupd", 32'(upd), 32'h0);

        // Glitch on digit 1: only the final run of four commits.
        cyc(1, 7'h6D, 4'b1101);
        cyc(1, 7'h6D, 4'b1101);
        cyc(1, 7'h66, 4'b1101);
        for (int i = 0; i < 3; i++) cyc(1, 7'h6D, 4'b1101);
        chk("glitch_pre_valid", 32'(valid[1]), 32'h0);
        chk("glitch_pre_digit", 32'(digits[7:4]), 32'h0);
        cyc(1, 7'h6D, 4'b1101);
        chk("glitch_digit", 32'(digits[7:4]), 32'h5);
        chk("glitch_valid", 32'(valid[1]), 32'h1);
        chk("glitch_upd", 32'(upd), 32'h1);

        // Illegal then blank on digit 2.
        for (int i = 0; i < 4; i++) cyc(1, 7'h01, 4'b1011);
        chk("illegal_bad", 32'(bad[2]), 32'h1);
        chk("illegal_valid", 32'(valid[2]), 32'h0);
        chk("illegal_upd", 32'(upd), 32'h1);
        for (int i = 0; i < 4; i++) cyc(1, 7'h00, 4'b1011);
        chk("blank_blank", 32'(blank[2]), 32'h1);
        chk("blank_bad", 32'(bad[2]), 32'h0);
        chk("blank_upd", 32'(upd), 32'h1);

        // Multi-select: flagged every cycle, never captured.
        for (int i = 0; i < 6; i++) begin
            cyc(1, 7'h06, 4'b1100);
            chk("multi_sel_err", 32'(sel_err), 32'h1);
        end
        chk("multi_no_commit", 32'(digits[7:0]), 32'h53);

        // Round-robin scan of all four digits.
        for (int k = 0; k < ND; k++)
            for (int i = 0; i < 8; i++) cyc(1, pat_tab[k], one_n(k));
        chk("rr_digits", 32'(digits), 32'h3210);
        chk("rr_valid", 32'(valid), 32'hF);

        // Digit 3 goes stale exactly TMO cycles after its last selection.
        for (int j = 1; j <= TMO; j++) begin
            d = (j - 1) % 3;
            cyc(1, pat_tab[d], one_n(d));
            if (j == TMO - 1) chk("tmo_pre_valid", 32'(valid[3]), 32'h1);
        end
        chk("tmo_valid", 32'(valid[3]), 32'h0);
        chk("tmo_digit_held", 32'(digits[15:12]), 32'h3);
        chk("tmo_upd", 32'(upd), 32'h1);

        // Reset in the middle of a scan.
        cyc(1, pat_tab[0], 4'b1110);
        cyc(0, pat_tab[1], 4'b1101);
        chk("midrst_digits", 32'(digits), 32'h0);
        chk("midrst_flags", 32'({valid, blank, bad, sel_err, upd}), 32'h0);

        // Randomized traffic.
        for (int b = 0; b < 500; b++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                len = $urandom_range(1, 2);
                for (int i = 0; i < len; i++) cyc(0, 7'($urandom), ND'($urandom));
            end else if (r < 8) begin
                len = $urandom_range(1, 80);
                for (int i = 0; i < len; i++) cyc(1, 7'($urandom), '1);
            end else if (r < 14) begin
                len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) begin
                    int x, y;
                    x = $urandom_range(0, ND - 1);
                    y = (x + $urandom_range(1, ND - 1)) % ND;
                    a = one_n(x) & one_n(y) & ND'($urandom);
                    cyc(1, 7'($urandom), a);
                end
            end else begin
                d = $urandom_range(0, ND - 1);
                r = $urandom_range(0, 99);
                if (r < 70)      p = pat_tab[$urandom_range(0, 15)];
                else if (r < 85) p = 7'h00;
                else             p = 7'($urandom);
                len = $urandom_range(1, 7);
                for (int i = 0; i < len; i++) begin
                    if ($urandom_range(0, 9) == 0) cyc(1, 7'($urandom), one_n(d));
                    else                           cyc(1, p, one_n(d));
                end
            end
        end

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_capture.md
Name: ssd_capture

Overview:
- Reader side of the 7-segment display path: passively monitors a multiplexed display bus (segment lines plus per-digit anode enables).
- Decodes each digit's segment pattern back to a 4-bit hex value and filters glitches with a per-digit stability counter.
- Flags illegal patterns, blank digits and stale digits.
- Used as a loopback checker and scoreboard front-end for the display driver, and for reading external display panels.

Parameters:
- NDIG, 4: number of multiplexed digits (1..8).
- STABLE_CNT, 4: consecutive identical selected-cycles required to commit a digit (2..255).
- TIMEOUT_CYC, 1024: cycles without a digit being selected before its valid flag clears (≥ 2).
- SEG_ACTIVE_LOW, 0: 1 = segment lines are inverted on the bus; they are inverted internally before decode.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- seg  in  7  segment lines; bit0 = a … bit6 = g; active-high after the SEG_ACTIVE_LOW correction.
- an_n  in  NDIG  active-low digit enables; bit i selects digit i.
- digits  out  4*NDIG  committed hex values; digit i occupies [4i+3:4i].
- valid  out  NDIG  digit i holds a committed, legal, non-stale value.
- blank  out  NDIG  digit i committed as all-segments-off.
- bad  out  NDIG  digit i committed with an illegal pattern.
- sel_err  out  1  one-cycle pulse when more than one bit of an_n is low.
- upd  out  1  one-cycle pulse when any digit's committed {value, valid, blank, bad} changes.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n = 0 at a rising edge): digits, valid, blank, bad, sel_err and upd all 0. Internal last-pattern registers cleared to 0. Stability counters cleared to 0. Timeout counters cleared to 0. Reset mid-capture discards partial counts; capture restarts from scratch.
- Inputs are sampled directly; the bench drives them synchronously. No input synchronizer in this block.
- Selection, evaluated each cycle on the corrected seg:
  - exactly one bit of an_n low: digit d is selected.
  - no bit low: idle; nothing is committed.
  - more than one bit low: ignored for capture; sel_err = 1 on the following cycle.
- Legal decode table (pattern → value): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 67→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
- Blank: pattern 00 → blank.
- Illegal: any other pattern → bad.
- Stability, digit d selected with pattern p:
  - p == last_pat[d]: cnt[d] increments, saturating at STABLE_CNT.
  - otherwise: last_pat[d] ← p and cnt[d] ← 1.
- Commit: at the edge where cnt[d] becomes STABLE_CNT (from STABLE_CNT-1), the digit-d outputs update.
  - legal: digits[d] = value, valid = 1, blank = 0, bad = 0.
  - blank: digits[d] = 0, valid = 0, blank = 1, bad = 0.
  - illegal: digits[d] held, valid = 0, blank = 0, bad = 1.
- Commit latency: outputs change at the edge of the STABLE_CNT-th consecutive selected cycle with a constant pattern.
- While saturated, no re-commit occurs.
- Non-selected cycles (another digit selected, idle or multi-select) do not reset cnt[d]. Stability is counted over digit d's own selected cycles.
- upd pulses for one cycle, registered in the same cycle as the output change, only if the committed tuple differs from the previous tuple. Re-committing an identical value gives no upd.
- Timeout:
  - tmo[d] resets to 0 whenever digit d is selected; otherwise it increments, saturating at TIMEOUT_CYC.
  - When tmo[d] reaches TIMEOUT_CYC: valid[d] ← 0 and cnt[d] ← 0; digits[d], blank and bad are held; upd pulses if valid changed.
- Simultaneous commit of digit d and timeout of digit e: both apply; a single upd pulse.
- Counter widths: cnt uses $clog2(STABLE_CNT+1) bits; tmo uses $clog2(TIMEOUT_CYC+1) bits.

Decomposition:
- Shared package: segment bit-position constants (SEG_A..SEG_G), the 16 legal pattern constants and SEG_BLANK, shared with the display encoder and driver.
- Sub-module ssd_pattern_decode: purely combinational, 7-bit pattern → {value[3:0], legal, blank}. It is the inverse of the team's hex-to-segment encoder.
- One instance of ssd_pattern_decode, placed after the select mux. The per-digit state is a generate loop inside ssd_capture.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with random seg/an_n → all outputs 0; after release with an_n = all 1s for 10 cycles, outputs remain 0.
- Steady capture: an_n = 4'b1110, seg = 0x4F for 4 cycles → after the 4th edge digits[3:0] = 3, valid[0] = 1, upd pulses once. A 5th cycle produces no further upd.
- Glitch: digit 1 driven with 0x6D, 0x6D, 0x66, 0x6D ×4 → digit 1 commits 5 only after the final 4-run; no commit of 4.
- Illegal/blank: digit 2 with 0x01 ×4 → bad[2] = 1, valid[2] = 0. Then 0x00 ×4 → blank[2] = 1, bad[2] = 0. Each transition pulses upd once.
- Multi-select: an_n = 4'b1100 with 0x06 for 6 cycles → sel_err pulses every cycle, no commit on digits 0 or 1.
- Timeout/round-robin: scan 4 digits (0x3F, 0x06, 0x5B, 0x4F) with 8 cycles each → digits = 16'h3210, valid = 4'hF. Then stop selecting digit 3 while cycling digits 0–2 → valid[3] = 0 exactly TIMEOUT_CYC cycles after its last selection, digits[15:12] still 3. Assert rst_n = 0 mid-scan → all outputs clear next edge.
